// File: rtl/wc_pkg.sv
// Shared constants and types for the Winograd convolution front end.
package wc_pkg;

    localparam int DW = 10;
    localparam int M  = 5;
    localparam int R  = 5;
    localparam int N  = M + R - 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        STEP = 2'd1,
        PAD  = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/wc_window_shreg.sv
// N-sample sliding window: shifts one element in at the LSB end per enable,
// where the element is either the input sample or a zero.
module wc_window_shreg
    import wc_pkg::*;
#(
    parameter int DW = wc_pkg::DW,
    parameter int N  = wc_pkg::N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shift,
    input  logic            zero,
    input  logic            clr,
    input  logic [DW-1:0]   din,
    output logic [N*DW-1:0] next_window
);

    logic [N*DW-1:0] window_r;
    logic [DW-1:0]   elem_s;

    // next_window is the post-shift view so the tile register can capture it in the same edge
    always_comb begin
        elem_s      = zero ? {DW{1'b0}} : din;
        next_window = {window_r[(N-1)*DW-1:0], elem_s};
    end

    // Window storage; clear wins over shift so a new row starts from all zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_r <= {(N*DW){1'b0}};
        end else if (clr) begin
            window_r <= {(N*DW){1'b0}};
        end else if (shift) begin
            window_r <= next_window;
        end
    end

endmodule

// File: rtl/wc_tile_feeder.sv
// Builds overlapping N-sample tiles (stride M) from a serial sample stream,
// zero-padding the final tile of each row.
module wc_tile_feeder
    import wc_pkg::*;
#(
    parameter  int DW = wc_pkg::DW,
    parameter  int M  = wc_pkg::M,
    parameter  int R  = wc_pkg::R,
    localparam int N  = M + R - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_data,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_last,
    output logic [N*DW-1:0] tile,
    output logic            tile_valid,
    input  logic            tile_ready,
    output logic            tile_last,
    output logic [3:0]      tile_pad
);

    localparam logic [3:0] N_CNT = 4'(N);
    localparam logic [3:0] M_CNT = 4'(M);

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, pad_cnt_r, target_s, cnt_inc_s;
    logic            fill_r;
    logic [N*DW-1:0] tile_r, next_window_s;
    logic            tile_valid_r, tile_last_r;
    logic [3:0]      tile_pad_r;
    logic            shift_s, zero_s, clr_s, done_s, done_last_s, hs_s;

    wc_window_shreg #(.DW(DW), .N(N)) u_window (
        .clk         (clk),
        .rst         (rst),
        .shift       (shift_s),
        .zero        (zero_s),
        .clr         (clr_s),
        .din         (s_data),
        .next_window (next_window_s)
    );

    assign s_ready    = ((state_r == FILL) || (state_r == STEP)) && !rst;
    assign tile       = tile_r;
    assign tile_valid = tile_valid_r;
    assign tile_last  = tile_last_r;
    assign tile_pad   = tile_pad_r;

    // Next-state and per-cycle strobes; PAD reuses the row's FILL/STEP target
    always_comb begin
        state_s     = state_r;
        shift_s     = 1'b0;
        zero_s      = 1'b0;
        clr_s       = 1'b0;
        done_s      = 1'b0;
        done_last_s = 1'b0;
        hs_s        = 1'b0;
        target_s    = fill_r ? N_CNT : M_CNT;
        cnt_inc_s   = cnt_r + 4'd1;
        case (state_r)
            FILL, STEP: begin
                if (s_valid && s_ready) begin
                    shift_s = 1'b1;
                    if (cnt_inc_s == target_s) begin
                        done_s      = 1'b1;
                        done_last_s = s_last;
                        state_s     = HOLD;
                    end else if (s_last) begin
                        state_s = PAD;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            PAD: begin
                shift_s = 1'b1;
                zero_s  = 1'b1;
                if (cnt_inc_s == target_s) begin
                    done_s      = 1'b1;
                    done_last_s = 1'b1;
                    state_s     = HOLD;
                end else begin
                    state_s = PAD;
                end
            end
            HOLD: begin
                if (tile_ready) begin
                    hs_s    = 1'b1;
                    clr_s   = tile_last_r;
                    state_s = tile_last_r ? FILL : STEP;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters and the registered tile presented during HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r        <= 4'd0;
            pad_cnt_r    <= 4'd0;
            fill_r       <= 1'b1;
            tile_r       <= {(N*DW){1'b0}};
            tile_valid_r <= 1'b0;
            tile_last_r  <= 1'b0;
            tile_pad_r   <= 4'd0;
        end else if (done_s) begin
            cnt_r        <= 4'd0;
            pad_cnt_r    <= 4'd0;
            tile_r       <= next_window_s;
            tile_valid_r <= 1'b1;
            tile_last_r  <= done_last_s;
            tile_pad_r   <= pad_cnt_r + {3'd0, zero_s};
        end else begin
            if (shift_s) begin
                cnt_r <= cnt_inc_s;
            end
            if (zero_s) begin
                pad_cnt_r <= pad_cnt_r + 4'd1;
            end
            if (hs_s) begin
                tile_valid_r <= 1'b0;
                fill_r       <= tile_last_r;
            end
        end
    end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Randomized and directed checks of wc_tile_feeder against a row-level tiling model.
module tb_wc_tile_feeder;

    localparam logic [89:0] SPEC_T1 =
        90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101;

    typedef struct packed {
        logic [89:0] t;
        logic        l;
        logic [3:0]  p;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  s_data;
    logic        s_valid, s_ready, s_last;
    logic [89:0] tile;
    logic        tile_valid, tile_ready, tile_last;
    logic [3:0]  tile_pad;

    rec_t       obs_q[$];
    rec_t       exp_q[$];
    logic [9:0] row_hist[$];
    int         checks = 0;
    int         errors = 0;

    wc_tile_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .tile       (tile),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_last  (tile_last),
        .tile_pad   (tile_pad)
    );

    always #5 clk = ~clk;

    // Record every tile handshake that the next rising edge will complete
    always @(negedge clk) begin
        if (!rst && tile_valid && tile_ready) obs_q.push_back({tile, tile_last, tile_pad});
    end

    // Tile k of a row covers samples 5k..5k+8; samples past the row end read as zero
    task automatic model_row(input logic [9:0] row[$], input bit ends);
        int L;
        L = row.size();
        exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            int s = 5 * k;
            int e = s + 8;
            logic [89:0] t;
            rec_t r;
            if (!ends && e > L - 1) break;
            t = '0;
            for (int j = 0; j < 9; j++) t = {t[79:0], (s + j < L) ? row[s + j] : 10'd0};
            r.t = t;
            r.l = ends && (e >= L - 1);
            r.p = r.l ? 4'(e - (L - 1)) : 4'd0;
            exp_q.push_back(r);
            if (r.l) break;
        end
    endtask

    // Offer samples in order; returns at the negedge before the final accepting edge
    task automatic drive_row(input logic [9:0] row[$], input bit with_last,
                             input int valid_pct, input int ready_pct);
        int idx = 0;
        int guard = 0;
        while (idx < row.size() && guard < 3000) begin
            @(posedge clk); #1;
            s_valid    = ($urandom_range(99) < valid_pct);
            s_data     = row[idx];
            s_last     = with_last && (idx == row.size() - 1);
            tile_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            guard++;
        end
        checks++;
        if (idx != row.size()) begin
            errors++;
            $display("FAIL drive_row: accepted %0d samples, required %0d", idx, row.size());
        end
    endtask

    task automatic drain(input int ready_pct, input int n);
        int guard = 0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        while (obs_q.size() < n && guard < 500) begin
            tile_ready = ($urandom_range(99) < ready_pct);
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (obs_q.size() != n) begin
            errors++;
            $display("FAIL drain: got %0d tiles, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; tile_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tile, tile_valid, tile_last, tile_pad, s_ready} !== 97'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b pad=%0d rdy=%b tile=%h, required all 0",
                     tile_valid, tile_last, tile_pad, s_ready, tile);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b valid=%b, required rdy=1 valid=0", s_ready, tile_valid);
        end
    endtask

    task automatic test_first_tile();
        logic [9:0] row[$];
        row = '{10'(2), 10'(-10), 10'(3), 10'(4), 10'(-13), 10'(-18), 10'(-16), 10'(-28), 10'(-11)};
        obs_q.delete();
        row_hist = row;
        drive_row(row, 1'b0, 100, 100);
        checks++;
        if (tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_early: got tile_valid=%b before 9th accept, required 0", tile_valid);
        end
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tile_valid !== 1'b1 || tile !== SPEC_T1 || tile_last !== 1'b0 || tile_pad !== 4'd0) begin
            errors++;
            $display("FAIL first_tile: got v=%b tile=%h last=%b pad=%0d, required v=1 tile=%h last=0 pad=0",
                     tile_valid, tile, tile_last, tile_pad, SPEC_T1);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_hold_rdy: got s_ready=%b, required 0", s_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_release: got rdy=%b valid=%b, required rdy=1 valid=0", s_ready, tile_valid);
        end
    endtask

    task automatic test_second_tile();
        logic [9:0]  row[$];
        logic [89:0] want;
        row  = '{10'(-19), 10'(-6), 10'(3), 10'(-9), 10'(-12)};
        want = {10'(-18), 10'(-16), 10'(-28), 10'(-11), 10'(-19), 10'(-6), 10'(3), 10'(-9), 10'(-12)};
        foreach (row[i]) row_hist.push_back(row[i]);
        drive_row(row, 1'b0, 100, 100);
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tile_valid !== 1'b1 || tile !== want || tile_last !== 1'b0 || tile_pad !== 4'd0) begin
            errors++;
            $display("FAIL second_tile: got v=%b tile=%h last=%b pad=%0d, required v=1 tile=%h",
                     tile_valid, tile, tile_last, tile_pad, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [9:0]  row[$];
        logic [89:0] held;
        for (int i = 0; i < 5; i++) row.push_back(10'($urandom));
        foreach (row[i]) row_hist.push_back(row[i]);
        drive_row(row, 1'b0, 100, 0);
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk);
        held = tile;
        model_row(row_hist, 1'b0);
        checks++;
        if (tile_valid !== 1'b1 || held !== exp_q[2].t) begin
            errors++;
            $display("FAIL bp_tile: got v=%b tile=%h, required v=1 tile=%h", tile_valid, held, exp_q[2].t);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (tile !== held || tile_valid !== 1'b1 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: got v=%b rdy=%b tile=%h, required v=1 rdy=0 tile=%h",
                         c, tile_valid, s_ready, tile, held);
            end
        end
        @(posedge clk); #1; tile_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got s_ready=%b, required 1", s_ready);
        end
        checks++;
        if (obs_q.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d tiles, required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_seq%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_step_pad();
        logic [9:0] row[$];
        int pc = 0;
        int guard = 0;
        row = '{10'd7, 10'd8, 10'd9};
        foreach (row[i]) row_hist.push_back(row[i]);
        drive_row(row, 1'b1, 100, 0);
        @(posedge clk); #1; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        while (!tile_valid && guard < 20) begin
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL pad_rdy: got s_ready=%b during PAD, required 0", s_ready);
            end
            pc++;
            @(posedge clk); #1;
            @(negedge clk);
            guard++;
        end
        model_row(row_hist, 1'b1);
        checks++;
        if (pc != 2) begin
            errors++;
            $display("FAIL pad_cycles: got %0d, required 2", pc);
        end
        checks++;
        if (tile !== exp_q[3].t || tile_last !== 1'b1 || tile_pad !== 4'd2 ||
            tile[49:0] !== {10'd7, 10'd8, 10'd9, 20'd0}) begin
            errors++;
            $display("FAIL pad_tile: got tile=%h last=%b pad=%0d, required tile=%h last=1 pad=2",
                     tile, tile_last, tile_pad, exp_q[3].t);
        end
        drain(100, 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL row_seq%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        row_hist.delete();
    endtask

    task automatic test_short_row();
        logic [9:0] row[$];
        int pc = 0;
        int guard = 0;
        row = '{10'd1, 10'd2, 10'd3, 10'd4};
        obs_q.delete();
        drive_row(row, 1'b1, 100, 0);
        @(posedge clk); #1; s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        while (!tile_valid && guard < 20) begin
            pc++;
            @(posedge clk); #1;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (pc != 5) begin
            errors++;
            $display("FAIL short_cycles: got %0d pad cycles, required 5", pc);
        end
        checks++;
        if (tile !== {10'd1, 10'd2, 10'd3, 10'd4, 50'd0} || tile_last !== 1'b1 || tile_pad !== 4'd5) begin
            errors++;
            $display("FAIL short_tile: got tile=%h last=%b pad=%0d, required 1,2,3,4,0.. last=1 pad=5",
                     tile, tile_last, tile_pad);
        end
        drain(100, 1);
    endtask

    task automatic test_async_reset();
        logic [9:0] row_a[$];
        logic [9:0] row_b[$];
        logic [9:0] row_c[$];
        for (int i = 0; i < 9; i++) row_a.push_back(10'($urandom));
        for (int i = 0; i < 3; i++) row_b.push_back(10'($urandom));
        for (int i = 0; i < 9; i++) row_c.push_back(10'($urandom));
        obs_q.delete();
        drive_row(row_a, 1'b0, 100, 100);
        drain(100, 1);
        drive_row(row_b, 1'b0, 100, 100);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({tile, tile_valid, tile_last, tile_pad, s_ready} !== 97'd0) begin
            errors++;
            $display("FAIL arst_outputs: got valid=%b last=%b pad=%0d rdy=%b tile=%h, required all 0",
                     tile_valid, tile_last, tile_pad, s_ready, tile);
        end
        s_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        obs_q.delete();
        drive_row(row_c, 1'b0, 100, 100);
        checks++;
        if (tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_early: got tile_valid=%b before 9th fresh accept, required 0", tile_valid);
        end
        @(posedge clk); #1; s_valid = 1'b0;
        @(negedge clk);
        model_row(row_c, 1'b0);
        checks++;
        if (tile_valid !== 1'b1 || tile !== exp_q[0].t) begin
            errors++;
            $display("FAIL arst_fresh: got v=%b tile=%h, required v=1 tile=%h", tile_valid, tile, exp_q[0].t);
        end
        drain(100, 1);
    endtask

    task automatic test_random();
        int fixed_len[3] = '{9, 14, 1};
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            logic [9:0] row[$];
            int len;
            len = (r < 3) ? fixed_len[r] : $urandom_range(2, 25);
            for (int i = 0; i < len; i++) row.push_back(10'($urandom));
            obs_q.delete();
            model_row(row, 1'b1);
            drive_row(row, 1'b1, 70, 60);
            drain(60, exp_q.size());
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_row%0d_tile%0d (len %0d): got %h, required %h",
                             r, i, len, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_tile();
        test_second_tile();
        test_backpressure();
        test_step_pad();
        test_short_row();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wc_tile_feeder.md
# wc_tile_feeder

Upstream stage of the Winograd convolution core `wc`. It takes a serial stream of signed samples, one per handshake, and builds the overlapping input tiles `wc` consumes. Each tile is N = M+R-1 = 9 samples; consecutive tiles advance by M = 5 samples and overlap by R-1 = 4. Each tile is presented as one packed word on a valid/ready interface, and row ends are zero-padded.

## Interface
Parameters:
- `DW`, 10, sample width (two's complement)
- `M`, 5, outputs per tile (tile stride)
- `R`, 5, filter taps
- `N`, M+R-1 = 9, tile length (derived, not overridable)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_data`  in  DW  input sample
- `s_valid`  in  1  sample valid
- `s_ready`  out  1  feeder accepts a sample this cycle
- `s_last`  in  1  accepted sample is the last of its row
- `tile`  out  N*DW  packed tile; oldest sample in `tile[N*DW-1 -: DW]`, newest in `tile[DW-1:0]`
- `tile_valid`  out  1  tile is presented
- `tile_ready`  in  1  consumer takes the tile
- `tile_last`  out  1  tile closes the row
- `tile_pad`  out  4  number of zero samples appended at the newest end of `tile` (0..N-1)

## Operation
- Accept: a sample is accepted when `s_valid && s_ready`.
  - The window register shifts left by DW.
  - The sample enters the LSB slot.
  - `cnt` increments.
- States:
  - FILL: collect N samples. Entered at reset and after every `tile_last` handshake, with the window cleared to 0.
  - STEP: collect M new samples. The R-1 retained samples form the overlap.
  - PAD: after `s_last` arrives on an incomplete tile, shift in one zero per cycle until `cnt` reaches the target (N in FILL, M in STEP). `pad_cnt` increments with each zero.
  - HOLD: `tile_valid`=1. `tile`, `tile_last` and `tile_pad` stay frozen until `tile_ready`.
- `s_ready` = (state is FILL or STEP) && !rst. `s_ready` is 0 in PAD and HOLD.
- Tile complete: the accepted sample (or inserted zero) reaches the target.
  - Load `tile` from the window including that element.
  - Set `tile_last` = (`s_last` was seen this row) and `tile_pad` = `pad_cnt`.
  - Clear `cnt` and go to HOLD.
- HOLD exit on `tile_ready`: go to FILL if `tile_last`, else STEP.
- `s_last` on the sample that exactly completes a tile: no PAD; `tile_last`=1, `tile_pad`=0.
- A row shorter than N: FILL pads up to N.
- No arithmetic is performed; samples pass bit-exact.
- Reset, including mid-operation, immediately clears all of the following: state=FILL, `cnt`=0, `pad_cnt`=0, window=0, `tile`=0, `tile_valid`=0, `tile_last`=0, `tile_pad`=0. A partially built tile is discarded.

## Timing
- `tile_valid` rises the cycle after the completing accept or pad insertion. Latency is 1 cycle, and `tile` is registered.
- A tile handshake completes in the cycle where `tile_valid && tile_ready`. `s_ready` returns to 1 in the next cycle.
- With `tile_ready` tied high:
  - First tile needs N accepts.
  - Each later tile needs M accepts.
  - Each tile costs 1 extra HOLD cycle, so steady-state throughput is 1 tile per M+1 cycles.
- PAD takes exactly (target − `cnt`) cycles.
- `tile_ready` while `tile_valid`=0 is ignored.
- `s_valid` is ignored while `s_ready`=0. The upstream holds its data.

## Structure
- Package `wc_pkg` holds:
  - `DW`, `M`, `R`, `N` constants
  - state enum {FILL, STEP, PAD, HOLD}
  - a `sample_t` typedef, signed [DW-1:0]
- One sub-module, `wc_window_shreg`: an N×DW shift register with shift-enable, a zero-insert select and synchronous clear, plus async reset.
- The FSM, counters and output registers live in `wc_tile_feeder`.

## Test plan
- Reset, then stream 2,-10,3,4,-13,-18,-16,-28,-11 with `tile_ready`=1. Required response: one cycle after the 9th accept, `tile` = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101, with `tile_last`=0 and `tile_pad`=0.
- Continue with -19,-6,3,-9,-12. Required response: the second tile is -18,-16,-28,-11,-19,-6,3,-9,-12 (MSB→LSB), delivered one cycle after the 5th accept.
- Hold `tile_ready`=0 for 3 cycles on a presented tile. Required response: `tile` stays stable and `s_ready`=0 throughout; no sample is dropped or duplicated; the next tile matches the expected window.
- In STEP, send 7,8,9 with `s_last` on 9. Required response: 2 PAD cycles, then `tile` ends ...,7,8,9,0,0 with `tile_last`=1 and `tile_pad`=2. After the handshake the next row needs 9 accepts.
- Send a 4-sample row 1,2,3,4 with `s_last`. Required response: `tile` = 1,2,3,4,0,0,0,0,0 with `tile_pad`=5 and `tile_last`=1.
- Assert `rst` asynchronously mid-STEP with 3 samples collected. Required response: all outputs are 0 in the same cycle; after release, FILL requires 9 fresh samples and no stale data appears.
